// File: rtl/spi_reg_bank.sv
// spi_reg_bank: application-side register bank behind the SPI peripheral.
// Holds ID, CTRL, IRQ status/mask, error counter and general-purpose registers,
// and drives the status byte the peripheral shifts out at the start of a frame.
// Optional down-counting timer: define SPI_REG_BANK_TIMER_EN to build it in.
module spi_reg_bank #(
  parameter int               REG_W    = 8,
  parameter logic [REG_W-1:0] ID_VALUE = 8'hA5,
  parameter int               NUM_GP   = 4,
  parameter int               PRESCALE = 16
) (
  input  logic                    clk,
  input  logic                    rstb,
  input  logic                    ena,
  input  logic [REG_W-2:0]        addr,
  input  logic [REG_W-1:0]        wdata,
  input  logic                    we,
  output logic [REG_W-1:0]        rdata,
  input  logic [REG_W-2:0]        evt_in,
  output logic [REG_W-1:0]        status,
  output logic                    irq,
  output logic [NUM_GP*REG_W-1:0] gp_out
);

  localparam int AW = REG_W - 1;
  localparam logic [AW-1:0]    A_ID   = AW'(0);
  localparam logic [AW-1:0]    A_CTRL = AW'(1);
  localparam logic [AW-1:0]    A_STAT = AW'(2);
  localparam logic [AW-1:0]    A_MASK = AW'(3);
  localparam logic [AW-1:0]    A_ERR  = AW'(6);
  localparam int               A_GP0  = 8;
  localparam logic [REG_W-1:0] ERR_MAX = '1;

`ifdef SPI_REG_BANK_TIMER_EN
  localparam logic [AW-1:0]    A_RELOAD  = AW'(4);
  localparam logic [AW-1:0]    A_COUNT   = AW'(5);
  localparam logic [REG_W-1:0] CTRL_MASK = REG_W'(3'b111);
  localparam int               PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PRESC_LAST = PW'(PRESCALE - 1);

  logic [REG_W-1:0] reload_q, reload_d, count_q, count_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             wr_reload_s;
`else
  localparam logic [REG_W-1:0] CTRL_MASK = REG_W'(1'b1);
`endif

  logic [REG_W-1:0]             ctrl_q, ctrl_d;
  logic [REG_W-1:0]             irq_status_q, irq_status_d;
  logic [REG_W-1:0]             irq_mask_q, irq_mask_d;
  logic [REG_W-1:0]             err_q, err_d;
  logic [REG_W-2:0]             evt_q, evt_d;
  logic [NUM_GP-1:0][REG_W-1:0] gp_q, gp_d;
  logic                         alive_q;

  logic              wr_s, wr_ctrl_s, wr_stat_s, wr_mask_s, wr_err_s, wr_known_s;
  logic [NUM_GP-1:0] gp_hit_s;
  logic              expire_s, tmr_stop_s;
  logic [REG_W-1:0]  rdata_s;

  // Address decode and write qualification (a write only counts with ena high)
  always_comb begin
    wr_s      = we & ena;
    wr_ctrl_s = wr_s & (addr == A_CTRL);
    wr_stat_s = wr_s & (addr == A_STAT);
    wr_mask_s = wr_s & (addr == A_MASK);
    wr_err_s  = wr_s & (addr == A_ERR);
    for (int i = 0; i < NUM_GP; i++) begin
      gp_hit_s[i] = (addr == AW'(A_GP0 + i));
    end
    wr_known_s = wr_ctrl_s | wr_stat_s | wr_mask_s | wr_err_s | (wr_s & (|gp_hit_s));
`ifdef SPI_REG_BANK_TIMER_EN
    wr_reload_s = wr_s & (addr == A_RELOAD);
    wr_known_s  = wr_known_s | wr_reload_s;
`endif
  end

`ifdef SPI_REG_BANK_TIMER_EN
  // Timer: prescaler and down-counter; a RELOAD write overrides any tick in the same cycle
  always_comb begin
    reload_d   = reload_q;
    count_d    = count_q;
    presc_d    = presc_q;
    expire_s   = 1'b0;
    tmr_stop_s = 1'b0;
    if (!ena) begin
      presc_d = presc_q;
    end else if (wr_reload_s) begin
      reload_d = wdata;
      count_d  = wdata;
      presc_d  = '0;
    end else if (ctrl_q[1]) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        if (count_q != '0) begin
          count_d = count_q - 1'b1;
        end else begin
          expire_s   = 1'b1;
          count_d    = reload_q;
          tmr_stop_s = ~ctrl_q[2];
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end else begin
      presc_d = '0;
    end
    // Starting the timer from stopped, or stopping it, restarts the prescaler at 0
    presc_d = (wr_ctrl_s && (!wdata[1] || !ctrl_q[1])) ? '0 : presc_d;
  end

  // Timer state registers
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      reload_q <= '0;
      count_q  <= '0;
      presc_q  <= '0;
    end else begin
      reload_q <= reload_d;
      count_q  <= count_d;
      presc_q  <= presc_d;
    end
  end
`else
  assign expire_s   = 1'b0;
  assign tmr_stop_s = 1'b0;
`endif

  // Next-state for control, interrupt, error and GP registers; everything holds with ena low
  always_comb begin
    ctrl_d       = ctrl_q;
    irq_status_d = irq_status_q;
    irq_mask_d   = irq_mask_q;
    err_d        = err_q;
    evt_d        = evt_q;
    gp_d         = gp_q;
    if (ena) begin
      evt_d = evt_in;
      // Set beats W1C clear on the same bit
      irq_status_d = (irq_status_q & ~(wr_stat_s ? wdata : '0)) | {expire_s, evt_in & ~evt_q};
      ctrl_d = wr_ctrl_s ? (wdata & CTRL_MASK)
                         : (ctrl_q & ~{{(REG_W-2){1'b0}}, tmr_stop_s, 1'b0});
      irq_mask_d = wr_mask_s ? wdata : irq_mask_q;
      if (wr_err_s) begin
        err_d = '0;
      end else if (wr_s && !wr_known_s && (err_q != ERR_MAX)) begin
        err_d = err_q + 1'b1;
      end else begin
        err_d = err_q;
      end
      for (int i = 0; i < NUM_GP; i++) begin
        gp_d[i] = (wr_s && gp_hit_s[i]) ? wdata : gp_q[i];
      end
    end else begin
      evt_d = evt_q;
    end
  end

  // Main register file
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      ctrl_q       <= '0;
      irq_status_q <= '0;
      irq_mask_q   <= '0;
      err_q        <= '0;
      evt_q        <= '0;
      gp_q         <= '0;
      alive_q      <= 1'b0;
    end else begin
      ctrl_q       <= ctrl_d;
      irq_status_q <= irq_status_d;
      irq_mask_q   <= irq_mask_d;
      err_q        <= err_d;
      evt_q        <= evt_d;
      gp_q         <= gp_d;
      alive_q      <= 1'b1;
    end
  end

  // Read mux: combinational on addr, unmapped addresses read 0; ID reads 0 until the first edge out of reset
  always_comb begin
    rdata_s = '0;
    case (addr)
      A_ID:     rdata_s = alive_q ? ID_VALUE : '0;
      A_CTRL:   rdata_s = ctrl_q;
      A_STAT:   rdata_s = irq_status_q;
      A_MASK:   rdata_s = irq_mask_q;
`ifdef SPI_REG_BANK_TIMER_EN
      A_RELOAD: rdata_s = reload_q;
      A_COUNT:  rdata_s = count_q;
`endif
      A_ERR:    rdata_s = err_q;
      default: begin
        for (int i = 0; i < NUM_GP; i++) begin
          rdata_s = rdata_s | (gp_q[i] & {REG_W{gp_hit_s[i]}});
        end
      end
    endcase
  end

  assign rdata  = rdata_s;
  assign status = irq_status_q & irq_mask_q;
  assign irq    = ctrl_q[0] & (|status);
  assign gp_out = gp_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Self-checking bench for spi_reg_bank: directed scenarios followed by random
// traffic, all compared against a behavioural model of the register map.
module tb_spi_reg_bank;
  localparam int NGP = 4;
  localparam int PRE = 16;
`ifdef SPI_REG_BANK_TIMER_EN
  localparam logic [7:0] CMASK = 8'h07;
`else
  localparam logic [7:0] CMASK = 8'h01;
`endif

  logic        clk = 1'b0;
  logic        rstb, ena, we, irq;
  logic [6:0]  addr, evt_in, cur_ev;
  logic [7:0]  wdata, rdata, status;
  logic [31:0] gp_out;

  always #5 clk = ~clk;

  spi_reg_bank #(.REG_W(8), .ID_VALUE(8'hA5), .NUM_GP(NGP), .PRESCALE(PRE)) dut (
    .clk(clk), .rstb(rstb), .ena(ena), .addr(addr), .wdata(wdata), .we(we),
    .rdata(rdata), .evt_in(evt_in), .status(status), .irq(irq), .gp_out(gp_out)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] m_ctrl, m_stat, m_mask, m_err;
  logic [6:0] m_evt;
  logic [7:0] m_gp [NGP];
  bit         m_alive;
`ifdef SPI_REG_BANK_TIMER_EN
  logic [7:0] m_reload, m_count;
  int         m_presc;
`endif

  function automatic void m_reset();
    m_ctrl = 8'h00; m_stat = 8'h00; m_mask = 8'h00; m_err = 8'h00;
    m_evt = 7'h00; m_alive = 1'b0;
    for (int i = 0; i < NGP; i++) m_gp[i] = 8'h00;
`ifdef SPI_REG_BANK_TIMER_EN
    m_reload = 8'h00; m_count = 8'h00; m_presc = 0;
`endif
  endfunction

  function automatic bit is_gp(input logic [6:0] a);
    return (int'(a) >= 8) && (int'(a) < 8 + NGP);
  endfunction

  function automatic bit m_writable(input logic [6:0] a);
    bit ok;
    ok = (a == 7'd1) || (a == 7'd2) || (a == 7'd3) || (a == 7'd6) || is_gp(a);
`ifdef SPI_REG_BANK_TIMER_EN
    ok = ok || (a == 7'd4);
`endif
    return ok;
  endfunction

  function automatic logic [7:0] m_read(input logic [6:0] a);
    if (a == 7'd0) return m_alive ? 8'hA5 : 8'h00;
    if (a == 7'd1) return m_ctrl;
    if (a == 7'd2) return m_stat;
    if (a == 7'd3) return m_mask;
`ifdef SPI_REG_BANK_TIMER_EN
    if (a == 7'd4) return m_reload;
    if (a == 7'd5) return m_count;
`endif
    if (a == 7'd6) return m_err;
    if (is_gp(a)) return m_gp[int'(a) - 8];
    return 8'h00;
  endfunction

  function automatic logic [31:0] m_gp_flat();
    logic [31:0] f;
    for (int i = 0; i < NGP; i++) f[i*8 +: 8] = m_gp[i];
    return f;
  endfunction

  function automatic void m_step(input bit e, input bit w, input logic [6:0] a,
                                 input logic [7:0] d, input logic [6:0] ev);
    logic [7:0] old_ctrl;
    bit         expire;
    m_alive = 1'b1;
    if (!e) return;
    old_ctrl = m_ctrl;
    expire   = 1'b0;
`ifdef SPI_REG_BANK_TIMER_EN
    if (w && a == 7'd4) begin
      m_reload = d; m_count = d; m_presc = 0;
    end else if (old_ctrl[1]) begin
      if (m_presc == PRE - 1) begin
        m_presc = 0;
        if (m_count != 8'h00) m_count = m_count - 8'd1;
        else begin
          expire  = 1'b1;
          m_count = m_reload;
          if (!old_ctrl[2]) m_ctrl[1] = 1'b0;
        end
      end else m_presc = m_presc + 1;
    end
`endif
    m_stat = (m_stat & ~((w && a == 7'd2) ? d : 8'h00)) | {expire, ev & ~m_evt};
    m_evt  = ev;
    if (w && a == 7'd1) begin
      m_ctrl = d & CMASK;
`ifdef SPI_REG_BANK_TIMER_EN
      if (!m_ctrl[1] || !old_ctrl[1]) m_presc = 0;
`endif
    end
    if (w && a == 7'd3) m_mask = d;
    if (w && is_gp(a)) m_gp[int'(a) - 8] = d;
    if (w && a == 7'd6) m_err = 8'h00;
    else if (w && !m_writable(a) && m_err != 8'hFF) m_err = m_err + 8'd1;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input bit e, input bit w, input logic [6:0] a,
                     input logic [7:0] d, input logic [6:0] ev);
    ena = e; we = w; addr = a; wdata = d; evt_in = ev; cur_ev = ev;
    #1;
    chk_eq("rdata", rdata, m_read(a));
    @(posedge clk);
    #1;
    m_step(e, w, a, d, ev);
    chk_eq("status", status, m_stat & m_mask);
    chk_eq("irq", irq, m_ctrl[0] & (|(m_stat & m_mask)));
    chk_eq("gp_out", gp_out, m_gp_flat());
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    cyc(1'b1, 1'b1, a, d, cur_ev);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 7'h00, 8'h00, cur_ev);
  endtask

  task automatic rd_chk(input string tag, input logic [6:0] a, input logic [7:0] exp);
    ena = 1'b1; we = 1'b0; addr = a;
    #1;
    chk_eq(tag, rdata, exp);
  endtask

  initial begin
    logic [6:0] ra, rev;
    logic [7:0] rd;
    bit         re, rw;
    int         sel;
    int         hit_at;

    rstb = 1'b0; ena = 1'b0; we = 1'b0; addr = 7'h00; wdata = 8'h00;
    evt_in = 7'h00; cur_ev = 7'h00;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_eq("rst_rdata", rdata, 8'h00);
    chk_eq("rst_status", status, 8'h00);
    chk_eq("rst_irq", irq, 1'b0);
    chk_eq("rst_gp", gp_out, 32'h0);
    rstb = 1'b1;
    idle(1);
    rd_chk("id", 7'h00, 8'hA5);

    // General-purpose registers
    wr(7'h08, 8'h5A);
    wr(7'h0B, 8'hC3);
    chk_eq("gp_flat", gp_out, 32'hC300_005A);
    rd_chk("gp0", 7'h08, 8'h5A);
    rd_chk("gp3", 7'h0B, 8'hC3);

    // Event interrupt, W1C, and set-beats-clear
    wr(7'h03, 8'h01);
    wr(7'h01, 8'h01);
    cyc(1'b1, 1'b0, 7'h00, 8'h00, 7'h01);
    cyc(1'b1, 1'b0, 7'h00, 8'h00, 7'h00);
    rd_chk("evt_stat", 7'h02, 8'h01);
    chk_eq("evt_status", status, 8'h01);
    chk_eq("evt_irq", irq, 1'b1);
    wr(7'h02, 8'h01);
    chk_eq("w1c_irq", irq, 1'b0);
    cyc(1'b1, 1'b1, 7'h02, 8'h01, 7'h01);
    rd_chk("set_wins", 7'h02, 8'h01);
    cyc(1'b1, 1'b0, 7'h00, 8'h00, 7'h00);

    // Error counter: RO write, saturation, clear
    wr(7'h00, 8'h10);
    rd_chk("err_ro", 7'h06, 8'h01);
    for (int i = 0; i < 256; i++) wr(7'h70, 8'($urandom_range(0, 255)));
    rd_chk("err_sat", 7'h06, 8'hFF);
    wr(7'h06, 8'h33);
    rd_chk("err_clr", 7'h06, 8'h00);

    // ena low: writes ignored, short edges lost
    wr(7'h02, 8'hFF);
    cyc(1'b0, 1'b1, 7'h08, 8'hEE, 7'h01);
    cyc(1'b0, 1'b0, 7'h00, 8'h00, 7'h00);
    cyc(1'b1, 1'b0, 7'h00, 8'h00, 7'h00);
    rd_chk("ena_gp", 7'h08, 8'h5A);
    rd_chk("ena_evt", 7'h02, 8'h00);

`ifdef SPI_REG_BANK_TIMER_EN
    // Timer with autoreload
    wr(7'h04, 8'h03);
    wr(7'h03, 8'h80);
    wr(7'h01, 8'h07);
    hit_at = -1;
    for (int n = 1; n <= 200; n++) begin
      idle(1);
      if (hit_at < 0 && status[7]) hit_at = n;
    end
    chk_eq("tmr_first_expire", hit_at, (3 + 1) * PRE);
    rd_chk("tmr_count", 7'h05, 8'h03);
    rd_chk("tmr_ctrl_ar", 7'h01, 8'h07);
    // One-shot
    wr(7'h01, 8'h00);
    wr(7'h02, 8'hFF);
    wr(7'h04, 8'h03);
    wr(7'h01, 8'h03);
    idle(100);
    chk_eq("oneshot_status", status, 8'h80);
    rd_chk("oneshot_ctrl", 7'h01, 8'h01);
    wr(7'h02, 8'h80);
    idle(80);
    chk_eq("oneshot_stopped", status, 8'h00);
`else
    rd_chk("no_tmr_rd4", 7'h04, 8'h00);
    wr(7'h04, 8'h12);
    rd_chk("no_tmr_err", 7'h06, 8'h01);
    wr(7'h01, 8'h07);
    rd_chk("no_tmr_ctrl", 7'h01, 8'h01);
`endif

    // Asynchronous reset mid-cycle with a write pending
    ena = 1'b1; we = 1'b1; addr = 7'h09; wdata = 8'hFF;
    #2;
    rstb = 1'b0;
    #1;
    chk_eq("arst_gp", gp_out, 32'h0);
    chk_eq("arst_status", status, 8'h00);
    chk_eq("arst_irq", irq, 1'b0);
    @(posedge clk);
    #1;
    chk_eq("arst_pending", gp_out, 32'h0);
    m_reset();
    cur_ev = 7'h00;
    rstb = 1'b1;
    rd_chk("arst_id", 7'h00, 8'h00);
    idle(1);
    rd_chk("arst_id_up", 7'h00, 8'hA5);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      re  = ($urandom_range(0, 9) != 0);
      rw  = ($urandom_range(0, 2) == 0);
      sel = int'($urandom_range(0, 15));
      ra  = (sel < 12) ? 7'(sel) : 7'($urandom_range(0, 127));
      rd  = (ra == 7'd4) ? 8'($urandom_range(0, 5)) : 8'($urandom_range(0, 255));
      rev = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : cur_ev;
      cyc(re, rw, ra, rd, rev);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
